// File: rtl/apb_pkg.sv
// Shared APB bridge types: bus widths and the transfer-phase enumeration.
package apb_pkg;

   localparam int APB_ADDR_W = 10;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response streams plus the APB initiator pins of the bridge.
interface apb_master_bridge_if #(
   parameter int ADDR = apb_pkg::APB_ADDR_W,
   parameter int DATA = apb_pkg::APB_DATA_W
);

   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_write;
   logic [ADDR-1:0] cmd_addr;
   logic [DATA-1:0] cmd_wdata;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [DATA-1:0] rsp_rdata;
   logic            rsp_err;
   logic            rsp_timeout;

   logic            psel;
   logic            penable;
   logic            pwrite;
   logic [ADDR-1:0] paddr;
   logic [DATA-1:0] pwdata;
   logic            pready;
   logic [DATA-1:0] prdata;
   logic            pslverr;

   // Bridge side
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  pready, prdata, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata
   );

   // Requester plus completer side
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output pready, prdata, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata
   );

endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one command in, one SETUP/ACCESS transfer out, one response back.
// ACCESS may be stretched by pready and is optionally capped by TIMEOUT cycles.
module apb_master_bridge #(
   parameter int ADDR    = apb_pkg::APB_ADDR_W,
   parameter int DATA    = apb_pkg::APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                pclk,
   input  logic                preset,
   apb_master_bridge_if.master bus
);

   import apb_pkg::*;

   localparam logic [1:0] S_IDLE   = 2'(IDLE);
   localparam logic [1:0] S_SETUP  = 2'(SETUP);
   localparam logic [1:0] S_ACCESS = 2'(ACCESS);
   localparam logic [1:0] S_RESP   = 2'(RESP);

   // A zero TIMEOUT still needs a legal 1-bit counter; it is simply never compared.
   localparam int              CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0]   TO_LAST   = CW'(TO_LAST_I);
   localparam bit              TO_EN     = (TIMEOUT != 0);

   logic [1:0]      r_state;
   logic [CW-1:0]   r_wcnt;
   logic            r_pwrite;
   logic [ADDR-1:0] r_paddr;
   logic [DATA-1:0] r_pwdata;
   logic [DATA-1:0] r_rdata;
   logic            r_err;
   logic            r_timeout;

   logic            w_to_hit;
   logic            w_wcnt_sat;

   assign w_to_hit   = TO_EN && (r_wcnt == TO_LAST);
   assign w_wcnt_sat = &r_wcnt;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state   <= S_IDLE;
         r_wcnt    <= '0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_pwrite <= bus.cmd_write;
                  r_paddr  <= bus.cmd_addr;
                  r_pwdata <= bus.cmd_wdata;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_wcnt  <= '0;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               // A completing pready wins over a timeout landing in the same cycle.
               if (bus.pready) begin
                  r_rdata   <= r_pwrite ? '0 : bus.prdata;
                  r_err     <= bus.pslverr;
                  r_timeout <= 1'b0;
                  r_state   <= S_RESP;
               end else if (w_to_hit) begin
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= S_RESP;
               end else if (!w_wcnt_sat) begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Handshake and bus strobes decode straight from the state register.
   assign bus.cmd_ready   = (r_state == S_IDLE);
   assign bus.rsp_valid   = (r_state == S_RESP);
   assign bus.psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign bus.penable     = (r_state == S_ACCESS);
   assign bus.pwrite      = r_pwrite;
   assign bus.paddr       = r_paddr;
   assign bus.pwdata      = r_pwdata;
   assign bus.rsp_rdata   = r_rdata;
   assign bus.rsp_err     = r_err;
   assign bus.rsp_timeout = r_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge with a memory-style completer.
module tb_apb_master_bridge;

   localparam int TO = 4;

   logic pclk = 1'b0;
   logic preset;
   always #5 pclk = ~pclk;

   apb_master_bridge_if bus ();

   apb_master_bridge #(.TIMEOUT(TO)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   // Completer: holds pready low for cfg_waits ACCESS cycles, then completes.
   bit [31:0] slv_mem [1024];
   int        cfg_waits;
   bit        cfg_err;
   int        acc_cnt;

   assign bus.pready  = (acc_cnt == cfg_waits);
   assign bus.prdata  = slv_mem[bus.paddr];
   assign bus.pslverr = cfg_err;

   always @(posedge pclk) begin
      if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
      else if (!bus.penable) acc_cnt <= 0;
      if (bus.psel && bus.penable && bus.pready && bus.pwrite) slv_mem[bus.paddr] <= bus.pwdata;
   end

   // Reference: what a requester should observe, from transfer-level rules only.
   bit [31:0] ref_mem [1024];
   int        n_chk;
   int        n_fail;
   int        acc_wait;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] wd,
                       input int waits, input bit err, input int hold, input bit bp);
      bit          to;
      int          acc_exp;
      logic [31:0] rd_exp;
      bit          err_exp;
      int          lat;
      int          nacc;
      to      = (TO != 0) && (waits >= TO);
      acc_exp = to ? TO : waits + 1;
      rd_exp  = (to || wr) ? 32'h0 : ref_mem[a];
      err_exp = to ? 1'b1 : err;
      if (wr && !to) ref_mem[a] = wd;

      cfg_waits     = waits;
      cfg_err       = err;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = (hold == 0);
      acc_wait = 0;
      while (!bus.cmd_ready && acc_wait < 100) begin
         @(negedge pclk);
         acc_wait++;
      end
      chk("cmd_accept", bus.cmd_ready, 1'b1);

      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      chk("setup_bus", {bus.psel, bus.penable}, 2'b10);
      lat  = 1;
      nacc = 0;
      while (lat < 300) begin
         @(negedge pclk);
         lat++;
         if (bus.rsp_valid) break;
         if (bus.psel && bus.penable) begin
            nacc++;
            chk("access_stable", {bus.pwrite, bus.paddr, bus.pwdata}, {wr, a, wd});
         end
      end
      chk("rsp_latency", lat, 2 + acc_exp);
      chk("access_cycles", nacc, acc_exp);
      chk("resp_bus", {bus.psel, bus.penable, bus.cmd_ready}, 3'b000);
      chk("rsp_rdata", bus.rsp_rdata, rd_exp);
      chk("rsp_err", bus.rsp_err, err_exp);
      chk("rsp_timeout", bus.rsp_timeout, to);

      if (bp) bus.cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge pclk);
         chk("backpressure_hold",
             {bus.rsp_valid, bus.cmd_ready, bus.psel, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
             {1'b1, 1'b0, 1'b0, rd_exp, err_exp, to});
      end
      bus.rsp_ready = 1'b1;
      @(negedge pclk);
      chk("idle_after_rsp", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
   endtask

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      cfg_waits     = 0;
      cfg_err       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b1;
      preset        = 1'b1;
      #12;
      chk("reset_ctrl",
          {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.pwrite},
          7'b1000000);
      chk("reset_data", {bus.paddr, bus.pwdata, bus.rsp_rdata}, 74'h0);
      @(negedge pclk);
      preset = 1'b0;
      @(negedge pclk);

      // Zero-wait write then read back
      xfer(1'b1, 10'h003, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0);
      xfer(1'b0, 10'h003, 32'h0, 0, 1'b0, 0, 1'b0);

      // Three wait states before completion
      xfer(1'b1, 10'h010, 32'h12345678, 0, 1'b0, 0, 1'b0);
      xfer(1'b0, 10'h010, 32'hA5A5A5A5, 3, 1'b0, 0, 1'b0);

      // Completer never ready: timeout after TO ACCESS cycles
      xfer(1'b0, 10'h020, 32'h0, 50, 1'b0, 0, 1'b0);
      xfer(1'b1, 10'h021, 32'hCAFEF00D, 50, 1'b0, 0, 1'b0);

      // Slave error on a read
      xfer(1'b0, 10'h003, 32'h0, 0, 1'b1, 0, 1'b0);

      // Back-pressure with the next command already waiting
      xfer(1'b0, 10'h003, 32'h0, 0, 1'b0, 5, 1'b1);
      xfer(1'b0, 10'h003, 32'h0, 0, 1'b0, 0, 1'b0);
      chk("bp_next_accept_wait", acc_wait, 0);

      // Randomized traffic over a small address window
      for (int k = 0; k < 60; k++) begin
         xfer(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
              int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 2)), 1'b0);
      end

      // Reset in the middle of a stretched ACCESS
      cfg_waits     = 1000;
      cfg_err       = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 10'h005;
      bus.cmd_valid = 1'b1;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      @(negedge pclk);
      chk("pre_reset_access", {bus.psel, bus.penable}, 2'b11);
      #2 preset = 1'b1;
      #1;
      chk("reset_async_drop", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
      @(negedge pclk);
      preset = 1'b0;
      @(negedge pclk);
      chk("post_reset_idle", {bus.cmd_ready, bus.psel, bus.penable, bus.rsp_valid}, 4'b1000);
      xfer(1'b0, 10'h003, 32'h0, 1, 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
